// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator measurement scheduler.
// Holds the register byte offsets, the CTL/STAT bit positions and the FSM state encoding.
package ro_pkg;

    // Register byte offsets inside the 16-byte block
    localparam logic [3:0] OFS_CTL   = 4'h0;
    localparam logic [3:0] OFS_WIN   = 4'h2;
    localparam logic [3:0] OFS_THR_S = 4'h4;
    localparam logic [3:0] OFS_THR_L = 4'h6;
    localparam logic [3:0] OFS_RES_S = 4'h8;
    localparam logic [3:0] OFS_RES_L = 4'hA;
    localparam logic [3:0] OFS_STAT  = 4'hC;

    // CTL bit positions
    localparam int unsigned CTL_RUN     = 0;
    localparam int unsigned CTL_ONESHOT = 1;
    localparam int unsigned CTL_SEL_S   = 2;
    localparam int unsigned CTL_SEL_L   = 3;
    localparam int unsigned CTL_IE      = 7;

    // STAT bit positions
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_ALM_S = 1;
    localparam int unsigned STAT_ALM_L = 2;
    localparam int unsigned STAT_DONE  = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSettle  = 2'd1,
        StMeasure = 2'd2,
        StCapture = 2'd3
    } ro_state_e;

endpackage

// File: rtl/ro_meas_sched_if.sv
// Peripheral bus bundle for the RO measurement scheduler.
//   per_addr : word address          per_din  : write data
//   per_en   : access enable         per_we   : byte write enables (any set = write)
//   per_dout : read data, 0 when the block is not selected
interface ro_meas_sched_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr,
        output per_din,
        output per_en,
        output per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr,
        input  per_din,
        input  per_en,
        input  per_we,
        output per_dout
    );
endinterface

// File: rtl/ro_window_timer.sv
// Loadable down-counter shared by the settle and measure phases.
//   mclk, puc_rst : clock, asynchronous active-high reset
//   load_i        : load load_val_i (takes priority over counting)
//   load_val_i    : phase length in cycles
//   run_i         : phase active; count down and report terminal count
//   tc_o          : high during the last cycle of the loaded phase
module ro_window_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             run_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero load behaves as a one-cycle phase so the FSM can never stall.
    assign tc_o = run_i && (cnt_q <= Width'(1));

endmodule

// File: rtl/ro_meas_sched.sv
// Memory-mapped scheduler time-sharing the short and long ring oscillators.
// Enables one RO at a time, waits SETTLE_CYC cycles, counts RO edges over WIN mclk
// cycles, stores the wrap-safe delta, flags values below threshold and raises irq_ro.
//   mclk, puc_rst      : clock, asynchronous active-high reset
//   bus                : peripheral bus (slave side)
//   ro_short_cnt_i     : short-RO edge counter, mclk domain
//   ro_long_cnt_i      : long-RO edge counter, mclk domain
//   ro_short_en_o      : short-RO enable (registered)
//   ro_long_en_o       : long-RO enable (registered)
//   irq_ro_o           : level interrupt (registered)
module ro_meas_sched
    import ro_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR  = 15'h01A0,
    parameter int unsigned DEC_WD     = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    ro_meas_sched_if.slave        bus,
    input  logic [15:0]           ro_short_cnt_i,
    input  logic [15:0]           ro_long_cnt_i,
    output logic                  ro_short_en_o,
    output logic                  ro_long_en_o,
    output logic                  irq_ro_o
);

    localparam logic [15:0] SettleVal = 16'(SETTLE_CYC);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              reg_sel, reg_wr, reg_rd;
    logic [DEC_WD-1:0] reg_addr;

    assign reg_sel  = bus.per_en && (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_addr = {bus.per_addr[DEC_WD-2:0], 1'b0};
    assign reg_wr   = reg_sel && (bus.per_we != 2'b00);
    assign reg_rd   = reg_sel && (bus.per_we == 2'b00);

    logic wr_ctl, wr_win, wr_thr_s, wr_thr_l, wr_stat;

    assign wr_ctl   = reg_wr && (reg_addr == DEC_WD'(OFS_CTL));
    assign wr_win   = reg_wr && (reg_addr == DEC_WD'(OFS_WIN));
    assign wr_thr_s = reg_wr && (reg_addr == DEC_WD'(OFS_THR_S));
    assign wr_thr_l = reg_wr && (reg_addr == DEC_WD'(OFS_THR_L));
    assign wr_stat  = reg_wr && (reg_addr == DEC_WD'(OFS_STAT));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        run_q, run_d, oneshot_q, oneshot_d;
    logic        sel_s_q, sel_s_d, sel_l_q, sel_l_d, ie_q, ie_d;
    logic [15:0] win_q, win_d, thr_s_q, thr_s_d, thr_l_q, thr_l_d;
    logic [15:0] res_s_q, res_s_d, res_l_q, res_l_d;
    logic        alm_s_q, alm_s_d, alm_l_q, alm_l_d, done_q, done_d;
    logic        irq_q, irq_d;

    ro_state_e   state_q, state_d;
    logic        cur_long_q, cur_long_d;   // RO currently being measured
    logic        s_ran_q, s_ran_d, l_ran_q, l_ran_d;
    logic [15:0] start_q, start_d, end_q, end_d;
    logic        en_s_q, en_s_d, en_l_q, en_l_d;

    // FSM helpers
    logic        tmr_load, tmr_run, tmr_tc;
    logic [15:0] tmr_val;
    logic        cap, clr_oneshot;
    logic        sel_any, win_nz, go, armed, other_pend, active_d;
    logic [15:0] cnt_cur, delta;

    assign sel_any    = sel_s_q || sel_l_q;
    assign win_nz     = (win_q != 16'd0);
    assign armed      = run_q || oneshot_q;
    assign go         = armed && sel_any && win_nz;
    assign other_pend = cur_long_q ? (sel_s_q && !s_ran_q) : (sel_l_q && !l_ran_q);
    assign cnt_cur    = cur_long_q ? ro_long_cnt_i : ro_short_cnt_i;
    assign delta      = end_q - start_q;  // modulo 2^16 so counter wrap is harmless

    ro_window_timer #(
        .Width (16)
    ) u_timer (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .run_i      (tmr_run),
        .tc_o       (tmr_tc)
    );

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_long_d  = cur_long_q;
        s_ran_d     = s_ran_q;
        l_ran_d     = l_ran_q;
        start_d     = start_q;
        end_d       = end_q;
        tmr_load    = 1'b0;
        tmr_val     = SettleVal;
        tmr_run     = 1'b0;
        cap         = 1'b0;
        clr_oneshot = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d    = StSettle;
                    cur_long_d = !sel_s_q;
                    s_ran_d    = 1'b0;
                    l_ran_d    = 1'b0;
                    tmr_load   = 1'b1;
                end
            end
            StSettle: begin
                tmr_run = 1'b1;
                if (tmr_tc) begin
                    start_d  = cnt_cur;
                    tmr_load = 1'b1;
                    tmr_val  = win_q;   // window length frozen here
                    state_d  = StMeasure;
                end
            end
            StMeasure: begin
                tmr_run = 1'b1;
                if (tmr_tc) begin
                    end_d   = cnt_cur;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                cap = 1'b1;
                if (cur_long_q) begin
                    l_ran_d = 1'b1;
                end else begin
                    s_ran_d = 1'b1;
                end
                if (armed && other_pend) begin
                    state_d    = StSettle;
                    cur_long_d = !cur_long_q;
                    tmr_load   = 1'b1;
                end else if (run_q && sel_any && win_nz) begin
                    // New continuous sequence, short first
                    state_d    = StSettle;
                    cur_long_d = !sel_s_q;
                    s_ran_d    = 1'b0;
                    l_ran_d    = 1'b0;
                    tmr_load   = 1'b1;
                end else begin
                    state_d     = StIdle;
                    clr_oneshot = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Enables are registered from the next state so they line up with state_q.
    assign active_d = (state_d == StSettle) || (state_d == StMeasure);
    assign en_s_d   = active_d && !cur_long_d;
    assign en_l_d   = active_d && cur_long_d;

    // ------------------------------------------------------------------
    // Register file next state
    // ------------------------------------------------------------------
    always_comb begin
        run_d     = run_q;
        oneshot_d = oneshot_q;
        sel_s_d   = sel_s_q;
        sel_l_d   = sel_l_q;
        ie_d      = ie_q;
        if (clr_oneshot) begin
            oneshot_d = 1'b0;
        end
        if (wr_ctl) begin
            run_d     = bus.per_din[CTL_RUN];
            oneshot_d = bus.per_din[CTL_ONESHOT];
            sel_s_d   = bus.per_din[CTL_SEL_S];
            sel_l_d   = bus.per_din[CTL_SEL_L];
            ie_d      = bus.per_din[CTL_IE];
        end

        win_d   = wr_win   ? bus.per_din : win_q;
        thr_s_d = wr_thr_s ? bus.per_din : thr_s_q;
        thr_l_d = wr_thr_l ? bus.per_din : thr_l_q;

        res_s_d = (cap && !cur_long_q) ? delta : res_s_q;
        res_l_d = (cap && cur_long_q)  ? delta : res_l_q;

        // W1C first, then hardware set so a coincident set wins
        alm_s_d = (alm_s_q && !(wr_stat && bus.per_din[STAT_ALM_S]))
                  || (cap && !cur_long_q && (delta < thr_s_q));
        alm_l_d = (alm_l_q && !(wr_stat && bus.per_din[STAT_ALM_L]))
                  || (cap && cur_long_q && (delta < thr_l_q));
        done_d  = (done_q && !(wr_stat && bus.per_din[STAT_DONE])) || cap;

        irq_d = ie_q && (done_q || alm_s_q || alm_l_q);
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            run_q      <= 1'b0;
            oneshot_q  <= 1'b0;
            sel_s_q    <= 1'b0;
            sel_l_q    <= 1'b0;
            ie_q       <= 1'b0;
            win_q      <= '0;
            thr_s_q    <= '0;
            thr_l_q    <= '0;
            res_s_q    <= '0;
            res_l_q    <= '0;
            alm_s_q    <= 1'b0;
            alm_l_q    <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= StIdle;
            cur_long_q <= 1'b0;
            s_ran_q    <= 1'b0;
            l_ran_q    <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            en_s_q     <= 1'b0;
            en_l_q     <= 1'b0;
        end else begin
            run_q      <= run_d;
            oneshot_q  <= oneshot_d;
            sel_s_q    <= sel_s_d;
            sel_l_q    <= sel_l_d;
            ie_q       <= ie_d;
            win_q      <= win_d;
            thr_s_q    <= thr_s_d;
            thr_l_q    <= thr_l_d;
            res_s_q    <= res_s_d;
            res_l_q    <= res_l_d;
            alm_s_q    <= alm_s_d;
            alm_l_q    <= alm_l_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            cur_long_q <= cur_long_d;
            s_ran_q    <= s_ran_d;
            l_ran_q    <= l_ran_d;
            start_q    <= start_d;
            end_q      <= end_d;
            en_s_q     <= en_s_d;
            en_l_q     <= en_l_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [15:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (reg_rd) begin
            case (reg_addr)
                DEC_WD'(OFS_CTL): begin
                    rd_data[CTL_RUN]     = run_q;
                    rd_data[CTL_ONESHOT] = oneshot_q;
                    rd_data[CTL_SEL_S]   = sel_s_q;
                    rd_data[CTL_SEL_L]   = sel_l_q;
                    rd_data[CTL_IE]      = ie_q;
                end
                DEC_WD'(OFS_WIN):   rd_data = win_q;
                DEC_WD'(OFS_THR_S): rd_data = thr_s_q;
                DEC_WD'(OFS_THR_L): rd_data = thr_l_q;
                DEC_WD'(OFS_RES_S): rd_data = res_s_q;
                DEC_WD'(OFS_RES_L): rd_data = res_l_q;
                DEC_WD'(OFS_STAT): begin
                    rd_data[STAT_BUSY]  = (state_q != StIdle);
                    rd_data[STAT_ALM_S] = alm_s_q;
                    rd_data[STAT_ALM_L] = alm_l_q;
                    rd_data[STAT_DONE]  = done_q;
                end
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.per_dout  = rd_data;
    assign ro_short_en_o = en_s_q;
    assign ro_long_en_o  = en_l_q;
    assign irq_ro_o      = irq_q;

endmodule

// File: tb/tb_ro_meas_sched.sv
// Scoreboard bench for ro_meas_sched: the stimulus process pushes expected values,
// the monitor pops and compares on every bus read or probe strobe.
module tb_ro_meas_sched;

    localparam logic [13:0] BaseW = 14'h00D0;  // 15'h01A0 as a word address

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [15:0] ro_short_cnt, ro_long_cnt;
    logic        ro_short_en, ro_long_en, irq_ro;

    ro_meas_sched_if bus ();

    ro_meas_sched #(
        .BASE_ADDR  (15'h01A0),
        .DEC_WD     (4),
        .SETTLE_CYC (8)
    ) dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .bus            (bus),
        .ro_short_cnt_i (ro_short_cnt),
        .ro_long_cnt_i  (ro_long_cnt),
        .ro_short_en_o  (ro_short_en),
        .ro_long_en_o   (ro_long_en),
        .irq_ro_o       (irq_ro)
    );

    always #5 mclk = ~mclk;

    // Free-running RO counters, +1 per mclk, stepped at the falling edge
    logic [31:0] cyc = '0;
    logic [15:0] s_ofs = '0;
    assign ro_short_cnt = cyc[15:0] + s_ofs;
    assign ro_long_cnt  = cyc[15:0] + 16'h1234;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        probe_v = 1'b0;
    logic [15:0] probe_d = '0;
    logic        tb_done = 1'b0;

    int          s_tot = 0, l_tot = 0, ov_tot = 0;
    int          s_rise = 0, l_rise = 0;
    logic        s_prev = 1'b0, l_prev = 1'b0;

    // Monitor and meters
    initial begin
        exp_t        e;
        logic [15:0] act;
        logic        have;
        forever begin
            @(negedge mclk);
            cyc = cyc + 1;
            if (ro_short_en) s_tot++;
            if (ro_long_en) l_tot++;
            if (ro_short_en && ro_long_en) ov_tot++;
            if (ro_short_en && !s_prev) s_rise = int'(cyc);
            if (ro_long_en && !l_prev) l_rise = int'(cyc);
            s_prev = ro_short_en;
            l_prev = ro_long_en;

            have = 1'b0;
            act  = '0;
            if (bus.per_en && bus.per_we == 2'b00) begin
                have = 1'b1;
                act  = bus.per_dout;
            end else if (probe_v) begin
                have = 1'b1;
                act  = probe_d;
            end
            if (have) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got %h, nothing expected", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.val) begin
                        n_bad++;
                        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                    end
                end
            end

            if (tb_done) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: never observed, expected %h", e.name, e.val);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [15:0] data);
        bus.per_addr = BaseW + 14'(ofs >> 1);
        bus.per_din  = data;
        bus.per_we   = 2'b11;
        bus.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic rd_raw(input logic [13:0] waddr, input logic [15:0] ex, input string nm);
        exp_t e;
        e.name = nm;
        e.val  = ex;
        exp_q.push_back(e);
        bus.per_addr = waddr;
        bus.per_we   = 2'b00;
        bus.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus.per_en   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ofs, input logic [15:0] ex, input string nm);
        rd_raw(BaseW + 14'(ofs >> 1), ex, nm);
    endtask

    task automatic probe(input string nm, input logic [15:0] act, input logic [15:0] ex);
        exp_t e;
        e.name = nm;
        e.val  = ex;
        exp_q.push_back(e);
        probe_d = act;
        probe_v = 1'b1;
        @(posedge mclk);
        #1;
        probe_v = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        rd(4'h0, 16'h0000, {tag, "_ctl"});
        rd(4'h2, 16'h0000, {tag, "_win"});
        rd(4'h4, 16'h0000, {tag, "_thr_s"});
        rd(4'h6, 16'h0000, {tag, "_thr_l"});
        rd(4'h8, 16'h0000, {tag, "_res_s"});
        rd(4'hA, 16'h0000, {tag, "_res_l"});
        rd(4'hC, 16'h0000, {tag, "_stat"});
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int s0, l0, ov0;

        bus.per_addr = '0;
        bus.per_din  = '0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        puc_rst      = 1'b1;
        cycles(3);
        puc_rst = 1'b0;
        cycles(1);

        // Reset state
        read_all_zero("reset");
        probe("reset_en_s", {15'b0, ro_short_en}, 16'h0000);
        probe("reset_en_l", {15'b0, ro_long_en}, 16'h0000);
        probe("reset_irq", {15'b0, irq_ro}, 16'h0000);

        // Oneshot short, WIN=100, counter wraps through 0xFFFF
        wr(4'h2, 16'd100);
        wr(4'h4, 16'd50);
        s_ofs = 16'hFFC0 - cyc[15:0];
        s0 = s_tot;
        wr(4'h0, 16'h0006);
        cycles(130);
        probe("t1_short_en_cycles", 16'(s_tot - s0), 16'd108);
        rd(4'h8, 16'd100, "t1_res_s");
        rd(4'hC, 16'h0008, "t1_stat");
        rd(4'h0, 16'h0004, "t1_ctl_oneshot_cleared");

        // Both ROs, short first, both alarm, interrupt
        wr(4'hC, 16'h000E);
        wr(4'h2, 16'd20);
        wr(4'h4, 16'd30);
        wr(4'h6, 16'd30);
        s0 = s_tot; l0 = l_tot; ov0 = ov_tot;
        wr(4'h0, 16'h008E);
        cycles(80);
        probe("t2_short_cycles", 16'(s_tot - s0), 16'd28);
        probe("t2_long_cycles", 16'(l_tot - l0), 16'd28);
        probe("t2_overlap", 16'(ov_tot - ov0), 16'd0);
        probe("t2_short_first", {15'b0, (l_rise > s_rise)}, 16'h0001);
        rd(4'h8, 16'd20, "t2_res_s");
        rd(4'hA, 16'd20, "t2_res_l");
        rd(4'hC, 16'h000E, "t2_stat");
        rd(4'h0, 16'h008C, "t2_ctl");
        probe("t2_irq_set", {15'b0, irq_ro}, 16'h0001);
        wr(4'hC, 16'h000E);
        cycles(2);
        probe("t2_irq_clr", {15'b0, irq_ro}, 16'h0000);

        // Threshold boundary: equal does not alarm, one above does
        wr(4'h6, 16'd20);
        wr(4'h0, 16'h000A);
        cycles(40);
        rd(4'hC, 16'h0008, "t3_stat_eq_thr");
        rd(4'hA, 16'd20, "t3_res_l");
        wr(4'hC, 16'h000E);
        wr(4'h6, 16'd21);
        wr(4'h0, 16'h000A);
        cycles(40);
        rd(4'hC, 16'h000C, "t3_stat_thr_plus1");

        // RUN cleared during MEASURE: window completes, then idle
        wr(4'hC, 16'h000E);
        wr(4'h6, 16'd0);
        wr(4'h2, 16'd10);
        l0 = l_tot;
        wr(4'h0, 16'h0009);
        cycles(12);
        wr(4'h0, 16'h0008);
        cycles(60);
        probe("t4_long_cycles", 16'(l_tot - l0), 16'd18);
        rd(4'hA, 16'd10, "t4_res_l");
        rd(4'hC, 16'h0008, "t4_stat_idle");
        rd(4'h0, 16'h0008, "t4_ctl");

        // W1C coinciding with the CAPTURE set of ALM_S and DONE
        wr(4'h6, 16'd21);
        wr(4'h2, 16'd20);
        wr(4'h0, 16'h000A);
        cycles(40);
        wr(4'h4, 16'd30);
        wr(4'h0, 16'h0006);
        cycles(29);
        wr(4'hC, 16'h000E);
        cycles(2);
        rd(4'hC, 16'h000A, "t5_stat_set_wins");
        rd(4'h8, 16'd20, "t5_res_s");

        // Read-only and unmapped writes ignored; unselected reads return 0
        wr(4'hE, 16'hFFFF);
        wr(4'h8, 16'h1234);
        rd(4'hE, 16'h0000, "t5_unmapped_read");
        rd(4'h8, 16'd20, "t5_res_s_ro");
        rd_raw(BaseW + 14'd8, 16'h0000, "t5_unselected_read");

        // Asynchronous reset during MEASURE
        wr(4'h0, 16'h000A);
        cycles(12);
        probe("t6_long_en_before", {15'b0, ro_long_en}, 16'h0001);
        puc_rst = 1'b1;
        #1;
        probe("t6_long_en_async", {15'b0, ro_long_en}, 16'h0000);
        cycles(2);
        puc_rst = 1'b0;
        cycles(2);
        read_all_zero("t6");
        probe("t6_irq", {15'b0, irq_ro}, 16'h0000);
        probe("t6_long_en", {15'b0, ro_long_en}, 16'h0000);
        probe("t6_dout_idle", bus.per_dout, 16'h0000);

        cycles(2);
        tb_done = 1'b1;
    end

endmodule
